// File: rtl/dac_volume_ramp.sv
// -----------------------------------------------------------------------------
// dac_volume_ramp
//
// Takes the volume (0x30) and control (0x31) bytes from the SCL-domain
// register file into the system clock domain. A byte is accepted only once it
// has been stable for a set time. The block then steps the DAC attenuation
// towards the requested level and sequences the mute relay around zero volume.
//
// Parameters
//   STABLE_CYCLES : identical synchronised samples needed before accepting
//   STEP_DIV      : clk cycles per +/-1 volume step
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   reg_vol    in   requested volume, asynchronous to clk
//   reg_ctrl   in   bit0 mute request, bit1 ramp bypass, 7:2 ignored
//   vol_out    out  current volume to the DAC/attenuator
//   vol_load   out  one-cycle strobe, high while a freshly changed vol_out
//                   is first presented
//   mute_out   out  mute relay drive, 1 = muted
//   status     out  {busy, mute_out, 6'b0} for read-only register 0x34
//   vol_status out  copy of vol_out for read-only register 0x35
// -----------------------------------------------------------------------------
module dac_volume_ramp #(
    parameter int STABLE_CYCLES = 16,
    parameter int STEP_DIV      = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] reg_vol,
    input  logic [7:0] reg_ctrl,
    output logic [7:0] vol_out,
    output logic       vol_load,
    output logic       mute_out,
    output logic [7:0] status,
    output logic [7:0] vol_status
);

    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int TW = (STEP_DIV < 2) ? 1 : $clog2(STEP_DIV);

    localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(STEP_DIV - 1);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_MUTED = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Two-flop synchroniser for both bytes, plus a copy of the previous
    // synchronised sample for the stability filter.
    // ---------------------------------------------------------------------
    logic [15:0] raw_in;
    logic [15:0] meta_q;
    logic [15:0] sync_q;
    logic [15:0] prev_q;

    assign raw_in = {reg_ctrl, reg_vol};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_in;
            sync_q <= meta_q;
        end
    end

    // ---------------------------------------------------------------------
    // Stability filter and accepted target
    // ---------------------------------------------------------------------
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [7:0]    tgt_q,  tgt_d;
    logic [7:0]    ctrl_q, ctrl_d;
    logic          stable_load;

    always_comb begin
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        ctrl_d      = ctrl_q;
        stable_load = 1'b0;
        if (sync_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_FULL) begin
            cnt_d = cnt_q + CW'(1);
            // Load exactly once, on the edge the counter reaches full;
            // afterwards it saturates and no further loads occur.
            if (cnt_q == CNT_LAST) begin
                stable_load = 1'b1;
            end
        end
        if (stable_load) begin
            tgt_d  = sync_q[7:0];
            ctrl_d = sync_q[15:8];
        end
    end

    // ---------------------------------------------------------------------
    // Mute FSM and volume ramp
    // ---------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [7:0]    vol_q,   vol_d;
    logic [TW-1:0] tick_q,  tick_d;
    logic          vol_load_q, vol_load_d;
    logic [7:0]    eff;
    logic          busy;

    always_comb begin
        state_d    = state_q;
        vol_d      = vol_q;
        tick_d     = '0;
        eff        = ctrl_q[0] ? 8'd0 : tgt_q;

        unique case (state_q)
            S_RUN: begin
                // Relay closes only after the ramp has reached zero.
                if (ctrl_q[0] && (vol_q == 8'd0)) begin
                    state_d = S_MUTED;
                end
            end
            S_MUTED: begin
                // Relay opens first; the ramp starts from the RUN state.
                if (!ctrl_q[0]) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_MUTED;
        endcase

        // The tick counter only runs while a ramp is actually in progress.
        if ((state_q == S_RUN) && (vol_q != eff)) begin
            if (ctrl_q[1]) begin
                vol_d = eff;
            end else if (tick_q == TICK_MAX) begin
                // Direction chosen per step, so a retarget mid-ramp simply
                // turns around; unsigned compare keeps vol within 0..255.
                vol_d = (vol_q < eff) ? vol_q + 8'd1 : vol_q - 8'd1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end

        vol_load_d = (vol_d != vol_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            cnt_q      <= '0;
            tgt_q      <= 8'd0;
            ctrl_q     <= 8'h01;
            state_q    <= S_MUTED;
            vol_q      <= 8'd0;
            tick_q     <= '0;
            vol_load_q <= 1'b0;
        end else begin
            prev_q     <= sync_q;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            ctrl_q     <= ctrl_d;
            state_q    <= state_d;
            vol_q      <= vol_d;
            tick_q     <= tick_d;
            vol_load_q <= vol_load_d;
        end
    end

    assign mute_out   = (state_q == S_MUTED);
    assign busy       = (vol_q != eff) || (mute_out != ctrl_q[0]);
    assign vol_out    = vol_q;
    assign vol_load   = vol_load_q;
    assign vol_status = vol_q;
    assign status     = {busy, mute_out, 6'b000000};

endmodule

// File: tb/tb_dac_volume_ramp.sv
// -----------------------------------------------------------------------------
// Directed testbench for dac_volume_ramp with STABLE_CYCLES=4, STEP_DIV=4.
// Inputs change on the falling edge; "edge N" is the N-th rising edge after
// the change, and outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_dac_volume_ramp;

    logic       clk;
    logic       rst_n;
    logic [7:0] reg_vol;
    logic [7:0] reg_ctrl;
    logic [7:0] vol_out;
    logic       vol_load;
    logic       mute_out;
    logic [7:0] status;
    logic [7:0] vol_status;

    int         errors;
    int         checks;
    int         load_pulses;
    logic [7:0] prev_vol;

    dac_volume_ramp #(
        .STABLE_CYCLES(4),
        .STEP_DIV     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_vol   (reg_vol),
        .reg_ctrl  (reg_ctrl),
        .vol_out   (vol_out),
        .vol_load  (vol_load),
        .mute_out  (mute_out),
        .status    (status),
        .vol_status(vol_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: vol_load must be high exactly when vol_out has just changed.
    task automatic cyc();
        logic exp_load;
        @(posedge clk);
        @(negedge clk);
        exp_load = (vol_out !== prev_vol);
        checks++;
        assert (vol_load === exp_load) else begin
            errors++;
            $error("FAIL vol_load observed=%0b expected=%0b (vol %0d->%0d)",
                   vol_load, exp_load, prev_vol, vol_out);
        end
        if (vol_load === 1'b1) load_pulses++;
        prev_vol = vol_out;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        load_pulses = 0;
        prev_vol    = 8'd0;
        rst_n       = 1'b0;
        reg_vol     = 8'd0;
        reg_ctrl    = 8'h00;

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_vol_out", vol_out, 8'd0);
        chk("rst_mute", {7'd0, mute_out}, 8'd1);
        chk("rst_status", status, 8'h40);
        chk("rst_vol_status", vol_status, 8'd0);
        chk("rst_vol_load", {7'd0, vol_load}, 8'd0);
        $display("reset: vol=%0d mute=%0b status=%02h", vol_out, mute_out, status);
        rst_n = 1'b1;

        // ---- release: stays muted until ctrl 0x00 is accepted ----
        run(2);
        chk("rel_mute_early", {7'd0, mute_out}, 8'd1);
        run(10);
        chk("rel_mute_late", {7'd0, mute_out}, 8'd0);
        chk("rel_vol", vol_out, 8'd0);
        chk("rel_status", status, 8'h00);
        $display("release: mute=%0b status=%02h", mute_out, status);

        // ---- ramp 0 -> 5 ----
        load_pulses = 0;
        reg_vol = 8'd5;
        run(6);
        chk("up_status_e6", status, 8'h00);
        run(1);
        chk("up_status_e7", status, 8'h80);
        run(3);
        chk("up_vol_e10", vol_out, 8'd0);
        run(1);
        chk("up_vol_e11", vol_out, 8'd1);
        run(15);
        chk("up_vol_e26", vol_out, 8'd4);
        chk("up_busy_e26", status, 8'h80);
        run(1);
        chk("up_vol_e27", vol_out, 8'd5);
        chk("up_status_e27", status, 8'h00);
        chk("up_vol_status", vol_status, 8'd5);
        run(4);
        chk("up_pulses", load_pulses[7:0], 8'd5);
        $display("ramp up: vol=%0d pulses=%0d", vol_out, load_pulses);

        // ---- 2-cycle glitch 5 -> 9 -> 5 is rejected ----
        load_pulses = 0;
        reg_vol = 8'd9;
        run(2);
        reg_vol = 8'd5;
        run(20);
        chk("glitch_vol", vol_out, 8'd5);
        chk("glitch_pulses", load_pulses[7:0], 8'd0);
        chk("glitch_status", status, 8'h00);
        $display("glitch: vol=%0d pulses=%0d", vol_out, load_pulses);

        // ---- ramp down to 3 ----
        load_pulses = 0;
        reg_vol = 8'd3;
        run(16);
        chk("down3_vol", vol_out, 8'd3);
        chk("down3_pulses", load_pulses[7:0], 8'd2);
        $display("ramp down: vol=%0d pulses=%0d", vol_out, load_pulses);

        // ---- mute at vol 3: ramp to 0, then relay ----
        reg_ctrl = 8'h01;
        run(10);
        chk("mute_vol_e10", vol_out, 8'd3);
        run(1);
        chk("mute_vol_e11", vol_out, 8'd2);
        run(8);
        chk("mute_vol_e19", vol_out, 8'd0);
        chk("mute_relay_e19", {7'd0, mute_out}, 8'd0);
        chk("mute_status_e19", status, 8'h80);
        run(1);
        chk("mute_relay_e20", {7'd0, mute_out}, 8'd1);
        chk("mute_status_e20", status, 8'h40);
        $display("mute: vol=%0d mute=%0b status=%02h", vol_out, mute_out, status);

        // ---- unmute: relay opens, then ramp to 3 ----
        reg_ctrl = 8'h00;
        run(7);
        chk("unmute_relay_e7", {7'd0, mute_out}, 8'd1);
        chk("unmute_status_e7", status, 8'hC0);
        run(1);
        chk("unmute_relay_e8", {7'd0, mute_out}, 8'd0);
        chk("unmute_status_e8", status, 8'h80);
        run(3);
        chk("unmute_vol_e11", vol_out, 8'd0);
        run(1);
        chk("unmute_vol_e12", vol_out, 8'd1);
        run(8);
        chk("unmute_vol_e20", vol_out, 8'd3);
        chk("unmute_status_e20", status, 8'h00);
        $display("unmute: vol=%0d mute=%0b status=%02h", vol_out, mute_out, status);

        // ---- bypass: jumps in one edge ----
        load_pulses = 0;
        reg_ctrl = 8'h02;
        reg_vol  = 8'd10;
        run(7);
        chk("byp_vol_e7", vol_out, 8'd3);
        chk("byp_status_e7", status, 8'h80);
        run(1);
        chk("byp_vol_e8", vol_out, 8'd10);
        chk("byp_status_e8", status, 8'h00);
        load_pulses = 0;
        reg_vol = 8'd200;
        run(7);
        chk("byp200_vol_e7", vol_out, 8'd10);
        run(1);
        chk("byp200_vol_e8", vol_out, 8'd200);
        run(4);
        chk("byp200_pulses", load_pulses[7:0], 8'd1);
        $display("bypass: vol=%0d pulses=%0d", vol_out, load_pulses);

        // ---- bypass plus mute from 200 ----
        reg_ctrl = 8'h03;
        run(7);
        chk("bm_vol_e7", vol_out, 8'd200);
        run(1);
        chk("bm_vol_e8", vol_out, 8'd0);
        chk("bm_relay_e8", {7'd0, mute_out}, 8'd0);
        chk("bm_status_e8", status, 8'h80);
        run(1);
        chk("bm_relay_e9", {7'd0, mute_out}, 8'd1);
        chk("bm_status_e9", status, 8'h40);
        $display("bypass mute: vol=%0d mute=%0b", vol_out, mute_out);

        // ---- reach 50 by bypass, start a ramp, reset mid-ramp ----
        reg_ctrl = 8'h02;
        reg_vol  = 8'd50;
        run(9);
        chk("pre_rst_vol", vol_out, 8'd50);
        chk("pre_rst_mute", {7'd0, mute_out}, 8'd0);
        reg_ctrl = 8'h00;
        reg_vol  = 8'd100;
        run(10);
        chk("midramp_vol", vol_out, 8'd50);
        chk("midramp_status", status, 8'h80);
        rst_n = 1'b0;
        #1;
        chk("arst_vol", vol_out, 8'd0);
        chk("arst_mute", {7'd0, mute_out}, 8'd1);
        chk("arst_status", status, 8'h40);
        chk("arst_vol_status", vol_status, 8'd0);
        chk("arst_vol_load", {7'd0, vol_load}, 8'd0);
        $display("async reset: vol=%0d mute=%0b status=%02h", vol_out, mute_out, status);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        prev_vol = 8'd0;
        run(2);
        chk("post_rst_mute", {7'd0, mute_out}, 8'd1);
        chk("post_rst_vol", vol_out, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
